// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers reused across layers.
package cnn_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Rectify: negative samples clamp to zero.
    function automatic sample_t relu(input sample_t x);
        return x[DATA_W-1] ? sample_t'(0) : x;
    endfunction

    // Signed maximum of two samples.
    function automatic sample_t max2(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer: one write port, one synchronous read port with held data.
module pool_line_buf #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 12,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents need no reset since every even row rewrites them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; data holds until the next read so gaps are tolerated.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/relu_maxpool_2x2.sv
// Streaming ReLU + 2x2/stride-2 max-pool over a raster-ordered conv stream.
module relu_maxpool_2x2 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMG_W  = 24,
    parameter int unsigned IMG_H  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);
    import cnn_pkg::*;

    localparam int unsigned HALF_W = IMG_W / 2;
    localparam int unsigned COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned ADDR_W = (HALF_W > 2) ? $clog2(HALF_W) : 1;

    // Reject geometries the pooling window cannot tile.
    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
        $error("relu_maxpool_2x2: IMG_W must be even and >= 2");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
        $error("relu_maxpool_2x2: IMG_H must be even and >= 2");
    end
    if (DATA_W != $bits(sample_t)) begin : g_bad_data_w
        $error("relu_maxpool_2x2: DATA_W must match cnn_pkg sample width");
    end

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    sample_t           h_reg;
    sample_t           r_c;
    sample_t           hmax_c;
    sample_t           lb_rd_data;
    logic              col_last_c;
    logic              row_last_c;
    logic              lb_wr_c;
    logic              lb_rd_c;
    logic [ADDR_W-1:0] lb_addr_c;

    // Rectified sample, horizontal pair max and line-buffer controls.
    always_comb begin
        r_c        = relu(sample_t'(in_data));
        hmax_c     = max2(h_reg, r_c);
        col_last_c = (col == COL_W'(IMG_W - 1));
        row_last_c = (row == ROW_W'(IMG_H - 1));
        lb_wr_c    = in_valid && !rst && col[0] && !row[0];
        lb_rd_c    = in_valid && !rst && !col[0] && row[0];
        lb_addr_c  = ADDR_W'(col >> 1);
    end

    pool_line_buf #(
        .WIDTH  (DATA_W),
        .DEPTH  (HALF_W),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_wr_c),
        .wr_addr (lb_addr_c),
        .wr_data (hmax_c),
        .rd_en   (lb_rd_c),
        .rd_addr (lb_addr_c),
        .rd_data (lb_rd_data)
    );

    // Raster position counters, advanced per accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col_last_c) begin
                col <= '0;
                row <= row_last_c ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Left pixel of each horizontal pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg <= '0;
        end else if (in_valid && !col[0]) begin
            h_reg <= r_c;
        end
    end

    // Pooled output on the bottom-right pixel of each window.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid && col[0] && row[0]) begin
                out_valid  <= 1'b1;
                out_data   <= max2(lb_rd_data, hmax_c);
                frame_done <= col_last_c && row_last_c;
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Scoreboard bench for relu_maxpool_2x2 on a 4x4 feature map.
module tb_relu_maxpool_2x2;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          frame_done;

    typedef struct {
        logic [DW-1:0] d;
        logic          fd;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic [DW-1:0] pix [16];
    logic [DW-1:0] ex  [4];

    relu_maxpool_2x2 #(
        .DATA_W (16),
        .IMG_W  (4),
        .IMG_H  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one pixel; optionally log the output it should produce next cycle.
    task automatic send(input logic [DW-1:0] v, input int gap, input bit push,
                        input logic [DW-1:0] ed, input logic efd);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        if (push) begin
            e.d   = ed;
            e.fd  = efd;
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Send a 4x4 frame; windows complete on pixels 5, 7, 13, 15.
    task automatic send_frame(input logic [DW-1:0] p [16], input logic [DW-1:0] e [4], input int gap);
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (((i / 4) % 2 == 1) && (i % 2 == 1)) begin
                send(p[i], gap, 1'b1, e[k], (k == 3));
                k++;
            end else begin
                send(p[i], gap, 1'b0, '0, 1'b0);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (frame_done === 1'b1 && out_valid !== 1'b1) begin
            chk("frame_done_without_valid", 32'(frame_done), 32'(out_valid));
        end
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got 0x%0h with nothing expected (cycle %0d)", out_data, cyc);
            end else begin
                e = q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
                chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        rst = 1'b0;

        // Ramp 0..15, continuous.
        for (int i = 0; i < 16; i++) pix[i] = DW'(i);
        ex = '{16'd5, 16'd7, 16'd13, 16'd15};
        send_frame(pix, ex, 0);
        idle(3);

        // All negative: -1..-16.
        for (int i = 0; i < 16; i++) pix[i] = DW'(-(i + 1));
        ex = '{16'd0, 16'd0, 16'd0, 16'd0};
        send_frame(pix, ex, 0);
        idle(3);

        // Gapped ramp: valid every third cycle.
        for (int i = 0; i < 16; i++) pix[i] = DW'(i);
        ex = '{16'd5, 16'd7, 16'd13, 16'd15};
        send_frame(pix, ex, 2);
        idle(3);

        // Reset mid-frame: 100..104 accepted, 105 collides with reset and is dropped.
        for (int i = 0; i < 5; i++) send(DW'(100 + i), 0, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd105;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("post_reset_out_valid", 32'(out_valid), 0);
        chk("post_reset_out_data", 32'(out_data), 0);
        for (int i = 0; i < 16; i++) pix[i] = DW'(i);
        ex = '{16'd5, 16'd7, 16'd13, 16'd15};
        send_frame(pix, ex, 0);
        idle(3);

        // Back-to-back frames: ramp up then ramp down, no gap.
        send_frame(pix, ex, 0);
        for (int i = 0; i < 16; i++) pix[i] = DW'(15 - i);
        ex = '{16'd15, 16'd13, 16'd7, 16'd5};
        send_frame(pix, ex, 0);
        idle(3);

        // Extremes: signed compare and ReLU on boundary codes.
        for (int i = 0; i < 16; i++) pix[i] = 16'h0000;
        pix[0] = 16'h8000; pix[1] = 16'h7FFF; pix[4] = 16'hFFFF; pix[5] = 16'h0001;
        pix[2] = 16'h8000; pix[3] = 16'h8000; pix[6] = 16'hFFFF; pix[7] = 16'h8001;
        ex = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
        send_frame(pix, ex, 0);
        idle(5);

        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
